// File: rtl/data_memory_responder_if.sv
// rtl/data_memory_responder_if.sv - cache-controller memory port between initiator and data memory
// Signal names keep the responder-side _i/_o suffixes so both ends read the same.
interface data_memory_responder_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              enable_i;
  logic              write_i;
  logic [ADDR_W-1:0] addr_i;
  logic [LINE_W-1:0] data_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;
  logic              busy_o;

  modport master (
    output enable_i,
    output write_i,
    output addr_i,
    output data_i,
    input  ack_o,
    input  data_o,
    input  busy_o
  );

  modport slave (
    input  enable_i,
    input  write_i,
    input  addr_i,
    input  data_i,
    output ack_o,
    output data_o,
    output busy_o
  );
endinterface

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - line-granular data memory model with fixed-latency single-cycle ack
// One request in flight; the line array 'memory' is loaded and inspected hierarchically by benches.
module data_memory_responder #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic                  clock_i,
  input  logic                  rst_n_i,
  data_memory_responder_if.slave bus
);

  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  reg [LINE_W-1:0] memory [0:DEPTH-1];

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [LINE_W-1:0] data_q, data_d;
  logic              write_q, write_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              mem_we;

  // Tag and offset bits are don't-care: aliasing addresses share a line.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_i[ADDR_W-1:OFF_W+IDX_W], bus.addr_i[OFF_W-1:0]};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    data_d  = data_q;
    write_d = write_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.enable_i) begin
          write_d = bus.write_i;
          idx_d   = bus.addr_i[OFF_W +: IDX_W];
          wdata_d = bus.data_i;
          count_d = CNT_INIT;
          busy_d  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          if (write_q) begin
            mem_we = 1'b1;
          end else begin
            data_d = memory[idx_q];
          end
        end
      end
      ST_ACK: begin
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
    end
  end

  // Latched request fields only matter once IDLE accepts, so they need no reset.
  always_ff @(posedge clock_i) begin
    write_q <= write_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
  end

  // Reset wins over the commit edge, so a dropped write never lands.
  always_ff @(posedge clock_i) begin
    if (rst_n_i && mem_we) begin
      memory[idx_q] <= wdata_q;
    end
  end

  assign bus.ack_o  = ack_q;
  assign bus.busy_o = busy_q;
  assign bus.data_o = data_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - randomized bench with transaction-level model for two latency builds
module tb_data_memory_responder;
  localparam int LW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n [2];
  logic          en    [2];
  logic          wr    [2];
  logic [31:0]   addr  [2];
  logic [LW-1:0] din   [2];
  logic          ack   [2];
  logic          busy  [2];
  logic [LW-1:0] dout  [2];

  data_memory_responder_if bus_a ();
  data_memory_responder_if bus_b ();

  assign bus_a.enable_i = en[0];
  assign bus_a.write_i  = wr[0];
  assign bus_a.addr_i   = addr[0];
  assign bus_a.data_i   = din[0];
  assign ack[0]  = bus_a.ack_o;
  assign busy[0] = bus_a.busy_o;
  assign dout[0] = bus_a.data_o;

  assign bus_b.enable_i = en[1];
  assign bus_b.write_i  = wr[1];
  assign bus_b.addr_i   = addr[1];
  assign bus_b.data_i   = din[1];
  assign ack[1]  = bus_b.ack_o;
  assign busy[1] = bus_b.busy_o;
  assign dout[1] = bus_b.data_o;

  data_memory_responder #(.LATENCY(10)) dut_a (.clock_i(clk), .rst_n_i(rst_n[0]), .bus(bus_a));
  data_memory_responder #(.LATENCY(1))  dut_b (.clock_i(clk), .rst_n_i(rst_n[1]), .bus(bus_b));

  // Transaction model: an accepted request completes LATENCY edges after its accept edge.
  int            lat   [2] = '{10, 1};
  logic          out_m [2] = '{1'b0, 1'b0};
  logic          ack_m [2] = '{1'b0, 1'b0};
  int            t_m   [2] = '{0, 0};
  logic          wr_m  [2];
  logic [8:0]    idx_m [2];
  logic [LW-1:0] wd_m  [2];
  logic [LW-1:0] data_m[2] = '{'0, '0};
  logic [LW-1:0] mm    [2][512];
  int            ecnt = 0;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n[k]) begin
        out_m[k]  = 1'b0;
        ack_m[k]  = 1'b0;
        data_m[k] = '0;
      end else if (!out_m[k]) begin
        if (en[k]) begin
          out_m[k] = 1'b1;
          t_m[k]   = ecnt;
          wr_m[k]  = wr[k];
          idx_m[k] = addr[k][13:5];
          wd_m[k]  = din[k];
        end
      end else if (ecnt == t_m[k] + lat[k]) begin
        ack_m[k] = 1'b1;
        if (wr_m[k]) mm[k][idx_m[k]] = wd_m[k];
        else         data_m[k] = mm[k][idx_m[k]];
      end else if (ecnt == t_m[k] + lat[k] + 1) begin
        ack_m[k] = 1'b0;
        out_m[k] = 1'b0;
      end
    end
    ecnt++;
  end

  task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("m%0d_ack", k),  ack[k],  ack_m[k]);
        chk($sformatf("m%0d_busy", k), busy[k], out_m[k]);
        chk($sformatf("m%0d_data", k), dout[k], data_m[k]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic preload(input int k, input int i, input logic [LW-1:0] v);
    mm[k][i] = v;
    if (k == 0) dut_a.memory[i] = v;
    else        dut_b.memory[i] = v;
  endtask

  function automatic logic [LW-1:0] peek(input int k, input int i);
    if (k == 0) return dut_a.memory[i];
    return dut_b.memory[i];
  endfunction

  task automatic wait_ack(input int k, input string nm);
    int n;
    n = 0;
    while (!ack[k] && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (!ack[k]) begin
      errors++;
      $display("FAIL %s no ack within %0d cycles got=0 exp=1", nm, n);
    end
  endtask

  logic [LW-1:0] a5_line;
  logic [LW-1:0] v5;
  int            acks;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0;
      en[k]    = 1'b0;
      wr[k]    = 1'b0;
      addr[k]  = '0;
      din[k]   = '0;
      for (int i = 0; i < 512; i++) preload(k, i, rnd_line());
    end
    a5_line = {32{8'hA5}};

    step();
    cmp_en = 1'b1;
    step();
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ack", ack[k], 1'b0);
      chk("rst_busy", busy[k], 1'b0);
      chk("rst_data", dout[k], '0);
    end

    // Read line 3 through address 0x60: ack exactly after edge T+10.
    preload(0, 3, a5_line);
    en[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h60;
    step();
    en[0] = 1'b0;
    chk("t1_busy0", busy[0], 1'b1);
    for (int kk = 1; kk <= 11; kk++) begin
      step();
      chk("t1_ack", ack[0], kk == 10);
      chk("t1_busy", busy[0], kk <= 10);
      if (kk == 10) begin
        chk("t1_data", dout[0], a5_line);
        chk("t1_model", data_m[0], a5_line);
      end
    end

    // Write then read back through 0x80 (line 4).
    en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h80; din[0] = 256'h1234;
    step();
    en[0] = 1'b0;
    wait_ack(0, "t2_wr_ack");
    chk("t2_mem4", peek(0, 4), 256'h1234);
    step();
    en[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h80;
    step();
    en[0] = 1'b0;
    wait_ack(0, "t2_rd_ack");
    chk("t2_rd", dout[0], 256'h1234);
    step();

    // Reset in mid-wait drops the pending write.
    preload(0, 2, 256'hDEAD_BEEF);
    en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h40; din[0] = '1;
    step();
    en[0] = 1'b0;
    repeat (4) step();
    rst_n[0] = 1'b0;
    step();
    rst_n[0] = 1'b1;
    chk("t3_busy", busy[0], 1'b0);
    for (int kk = 0; kk < 12; kk++) begin
      chk("t3_noack", ack[0], 1'b0);
      step();
    end
    chk("t3_mem2", peek(0, 2), 256'hDEAD_BEEF);

    // 0x4020 aliases line 1.
    preload(0, 1, 256'h77);
    en[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h4020;
    step();
    en[0] = 1'b0;
    wait_ack(0, "t4_ack");
    chk("t4_data", dout[0], 256'h77);
    step();

    // Write accepted, then inputs churn during WAIT without effect.
    v5 = rnd_line();
    en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'hA0; din[0] = v5;
    step();
    for (int kk = 1; kk <= 10; kk++) begin
      if (kk <= 8) begin
        en[0] = 1'($urandom % 2); wr[0] = 1'($urandom % 2);
        addr[0] = $urandom; din[0] = rnd_line();
      end else begin
        en[0] = 1'b0;
      end
      step();
      chk("t5_ack", ack[0], kk == 10);
    end
    chk("t5_mem5", peek(0, 5), v5);
    step();

    // LATENCY=1 with enable held: one ack every third cycle.
    preload(1, 7, 256'hC0FFEE);
    en[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'hE0;
    acks = 0;
    for (int kk = 0; kk < 15; kk++) begin
      step();
      if (ack[1]) begin
        acks++;
        chk("t6_data", dout[1], 256'hC0FFEE);
      end
    end
    en[1] = 1'b0;
    chk("t6_acks", acks, 5);
    step();

    // Random traffic on both builds, biased to a few lines for read-after-write.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        rst_n[k] = ($urandom % 100) != 0;
        en[k]    = ($urandom % 3) == 0;
        wr[k]    = 1'($urandom % 2);
        addr[k]  = $urandom;
        if ($urandom % 4 != 0) addr[k][13:5] = 9'($urandom % 8);
        din[k]   = rnd_line();
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b1;
      en[k]    = 1'b0;
    end
    repeat (15) step();
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
